sp_com_align: RTL

SP_COM_ALIGN -- requirements
Module: sp_com_align

---
 rtl/sp_com_align.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sp_com_align.sv
// rtl/sp_com_align.sv - serial comma aligner: locks byte framing on repeated COM symbols
// and emits aligned bytes with a boundary strobe until the COM gap limit is exceeded.
module sp_com_align #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int          SYNC_COUNT = 4,
    parameter int          MAX_GAP    = 32
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    localparam int CW = $clog2(SYNC_COUNT + 1);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [CW-1:0] COM_LAST = CW'(SYNC_COUNT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(MAX_GAP - 1);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ALIGN,
        ST_ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0] com_cnt_q, com_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          strobe_q, strobe_d;
    logic          active_q, active_d;

    logic [7:0]    candidate;
    logic          is_com;
    logic          boundary;

    assign candidate = {shift_q[6:0], data_in};
    assign is_com    = (candidate == COM_SYMBOL);
    assign boundary  = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SEARCH;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            com_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = candidate;
        bit_cnt_d  = bit_cnt_q;
        com_cnt_d  = com_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        active_d   = active_q;

        case (state_q)
            ST_SEARCH: begin
                // Any bit position may match here; the match defines the framing.
                bit_cnt_d = 3'd0;
                valid_d   = 1'b0;
                active_d  = 1'b0;
                if (is_com) begin
                    com_cnt_d = CW'(1);
                    state_d   = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                valid_d   = 1'b0;
                if (boundary) begin
                    if (is_com) begin
                        if (com_cnt_q == COM_LAST) begin
                            state_d   = ST_ACTIVE;
                            active_d  = 1'b1;
                            gap_cnt_d = '0;
                        end else begin
                            com_cnt_d = com_cnt_q + CW'(1);
                        end
                    end else begin
                        state_d   = ST_SEARCH;
                        com_cnt_d = '0;
                    end
                end
            end

            ST_ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (is_com) begin
                        data_out_d = candidate;
                        strobe_d   = 1'b1;
                        valid_d    = 1'b0;
                        gap_cnt_d  = '0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        // Too long without a comma: drop this byte and hunt again.
                        state_d   = ST_SEARCH;
                        active_d  = 1'b0;
                        valid_d   = 1'b0;
                        com_cnt_d = '0;
                        gap_cnt_d = '0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        data_out_d = candidate;
                        strobe_d   = 1'b1;
                        valid_d    = 1'b1;
                        gap_cnt_d  = gap_cnt_q + GW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule
